pipe_buffer_ctrl: RTL

PIPE_BUFFER_CTRL -- requirements
Module: pipe_buffer_ctrl

---
 rtl/pipe_buffer_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_buffer_ctrl.sv
// Sequencer for a chain of Buffer32 pipeline registers: fill, run, stall, flush, drain.
// Optional stall watchdog enabled by defining PIPE_STALL_WDOG_EN.
module pipe_buffer_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int STALL_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  stall,
    input  logic                  flush,
    output logic [NUM_STAGES-1:0] buf_start,
    output logic [NUM_STAGES-1:0] buf_hold,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state,
    output logic                  stall_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_buf;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_active;
    logic                  w_flush;
    logic                  w_stall_ok;
    logic                  w_tmo;
    logic                  w_trip;
    logic                  w_inject;
    logic [NUM_STAGES-1:0] w_buf_nxt;
    logic [NUM_STAGES-1:0] w_hold;

    assign w_active   = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_flush    = flush && (r_state != S_IDLE);
    assign w_stall_ok = w_active && stall && !flush && !w_tmo;

    // Only injects valid data while the pipeline stays in FILL/RUN next cycle.
    assign w_inject = ((r_state == S_IDLE) && start)
                    || (w_active && !halt && !w_trip);

`ifdef PIPE_STALL_WDOG_EN
    localparam int CW = $clog2(STALL_MAX + 1);

    logic [CW-1:0] r_wdog;
    logic          r_tmo;

    assign w_trip = w_stall_ok && (r_wdog == CW'(STALL_MAX - 1));
    assign w_tmo  = r_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else if (w_stall_ok) begin
            r_wdog <= r_wdog + 1'b1;
            if (w_trip)
                r_tmo <= 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    // Without the watchdog a stall may last indefinitely.
    assign w_trip = 1'b0 && (STALL_MAX > 0);
    assign w_tmo  = 1'b0;
`endif

    always_comb begin
        w_buf_nxt = {r_buf[NUM_STAGES-2:0], w_inject};
        if (r_state == S_IDLE) begin
            w_buf_nxt    = '0;
            w_buf_nxt[0] = start;
        end else if (w_flush) begin
            for (int i = 0; i < NUM_STAGES; i++)
                if (i < FLUSH_DEPTH)
                    w_buf_nxt[i] = 1'b0;
        end else if (w_stall_ok) begin
            for (int i = 0; i < NUM_STAGES; i++)
                if (i < STALL_STAGE)
                    w_buf_nxt[i] = r_buf[i];
            w_buf_nxt[STALL_STAGE] = 1'b0;
        end
    end

    always_comb begin
        w_hold = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (i < STALL_STAGE)
                w_hold[i] = w_stall_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FILL;
                        r_busy  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (halt || w_trip)
                        r_state <= S_DRAIN;
                    else if (&r_buf)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (halt || w_trip)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (~|r_buf) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign buf_start     = r_buf;
    assign buf_hold      = w_hold;
    assign busy          = r_busy;
    assign done          = r_done;
    assign state         = r_state;
    assign stall_timeout = w_tmo;

endmodule
